// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and helpers.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ADDR = 3'd1,
    D_WAIT = 3'd2,
    I_ADDR = 3'd3,
    I_WAIT = 3'd4
  } arb_state_e;

  function automatic logic is_addr_state(input arb_state_e s);
    return (s == D_ADDR) || (s == I_ADDR);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and mem-stage ports onto one shared memory request
// channel; data accesses win ties, fetches are not starved.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ok,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  arb_state_e state_q, state_d;
  logic       grant_d, grant_i;
  logic       inst_done_q, data_done_q;
  logic       inst_done, data_done, all_done;
  logic       inst_elig, data_elig;
  logic       inst_fin, data_fin;

  // A side stays "done" until the pipeline advances, so a still-held request
  // that already completed is neither re-granted nor allowed to keep stalling.
  assign inst_done = inst_ok | inst_done_q;
  assign data_done = data_ok | data_done_q;
  assign all_done  = (~inst_req | inst_done) & (~data_req | data_done);
  assign stall     = (inst_req | data_req) & ~all_done;
  assign inst_elig = inst_req & ~inst_done;
  assign data_elig = data_req & ~data_done;

  assign inst_fin  = (state_q == I_WAIT) && mem_data_ok;
  assign data_fin  = (state_q == D_WAIT) && mem_data_ok;
  assign mem_req   = is_addr_state(state_q);

  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_elig) begin
          state_d = D_ADDR;
          grant_d = 1'b1;
        end else if (inst_elig) begin
          state_d = I_ADDR;
          grant_i = 1'b1;
        end
      end
      D_ADDR: if (mem_addr_ok) state_d = D_WAIT;
      D_WAIT: if (mem_data_ok) state_d = IDLE;
      I_ADDR: if (mem_addr_ok) state_d = I_WAIT;
      I_WAIT: if (mem_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      inst_ok     <= 1'b0;
      data_ok     <= 1'b0;
      inst_rdata  <= '0;
      data_rdata  <= '0;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_ok     <= inst_fin;
      data_ok     <= data_fin;
      inst_done_q <= stall & inst_done;
      data_done_q <= stall & data_done;
      if (grant_d) begin
        mem_addr  <= data_addr;
        mem_wr    <= data_wr;
        mem_wdata <= data_wdata;
      end else if (grant_i) begin
        mem_addr  <= inst_addr;
        mem_wr    <= 1'b0;
      end
      if (inst_fin)            inst_rdata <= mem_rdata;
      if (data_fin && !mem_wr) data_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ok(data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    step(); step();
    n_cmp++;
    if ({mem_req, mem_wr, inst_ok, data_ok, stall} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_wr, inst_ok, data_ok, stall});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, inst_rdata, data_rdata} !== 128'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, inst_rdata, data_rdata});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    inst_req = 1; inst_addr = 32'hBFC00000;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_req: got %b want 1", stall); end
    step();
    n_cmp++;
    if ({mem_req, mem_wr, mem_addr} !== {1'b1, 1'b0, 32'hBFC00000}) begin
      n_err++;
      $display("FAIL fetch_addr_phase: got %b/%b/%h want 1/0/bfc00000", mem_req, mem_wr, mem_addr);
    end
    mem_addr_ok = 1;
    step();
    n_cmp++;
    if ({mem_req, inst_ok} !== 2'b00) begin
      n_err++; $display("FAIL fetch_wait_phase: got %b want 00", {mem_req, inst_ok});
    end
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h24020005;
    step();
    mem_data_ok = 0; mem_rdata = '0;
    n_cmp++;
    if ({inst_ok, inst_rdata} !== {1'b1, 32'h24020005}) begin
      n_err++; $display("FAIL fetch_ok: got %b/%h want 1/24020005", inst_ok, inst_rdata);
    end
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_ok: got %b want 0", stall); end
    inst_req = 0;
    step();
    n_cmp++;
    if ({inst_ok, mem_req, inst_rdata} !== {2'b00, 32'h24020005}) begin
      n_err++; $display("FAIL fetch_after: got %b/%b/%h want 0/0/24020005", inst_ok, mem_req, inst_rdata);
    end
  endtask

  task automatic test_simultaneous();
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 0; data_addr = 32'h80000010; data_wdata = '0;
    step();
    n_cmp++;
    if ({mem_req, mem_wr, mem_addr} !== {1'b1, 1'b0, 32'h80000010}) begin
      n_err++; $display("FAIL sim_data_first: got %b/%b/%h want 1/0/80000010", mem_req, mem_wr, mem_addr);
    end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h12345678;
    step();
    mem_data_ok = 0;
    n_cmp++;
    if ({data_ok, data_rdata, stall} !== {1'b1, 32'h12345678, 1'b1}) begin
      n_err++; $display("FAIL sim_data_ok: got %b/%h/%b want 1/12345678/1", data_ok, data_rdata, stall);
    end
    step();
    n_cmp++;
    if ({mem_req, mem_addr, data_ok, stall} !== {1'b1, 32'hBFC00004, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL sim_inst_grant: got %b/%h/%b/%b want 1/bfc00004/0/1", mem_req, mem_addr, data_ok, stall);
    end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h8C880000;
    step();
    mem_data_ok = 0;
    n_cmp++;
    if ({inst_ok, inst_rdata, data_rdata, stall} !== {1'b1, 32'h8C880000, 32'h12345678, 1'b0}) begin
      n_err++; $display("FAIL sim_inst_ok: got %b/%h/%h/%b want 1/8c880000/12345678/0", inst_ok, inst_rdata, data_rdata, stall);
    end
    inst_req = 0; data_req = 0;
    step();
    n_cmp++;
    if ({mem_req, inst_ok, data_ok} !== 3'b000) begin
      n_err++; $display("FAIL sim_no_regrant: got %b want 000", {mem_req, inst_ok, data_ok});
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    data_req = 1; data_wr = 1; data_addr = 32'h80000020; data_wdata = 32'hDEADBEEF;
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      n_cmp++;
      if ({mem_req, mem_wr, mem_addr, mem_wdata, data_ok} !== {2'b11, 32'h80000020, 32'hDEADBEEF, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got %b/%b/%h/%h/%b want 1/1/80000020/deadbeef/0", i, mem_req, mem_wr, mem_addr, mem_wdata, data_ok);
      end
      if (i == 0) begin data_addr = 32'h0; data_wdata = 32'h0; end
      mem_data_ok = (i == 2);
      if (i == 4) mem_addr_ok = 1;
      step();
    end
    mem_addr_ok = 0;
    n_cmp++;
    if ({mem_req, data_ok} !== 2'b00) begin
      n_err++; $display("FAIL bp_wait: got %b want 00", {mem_req, data_ok});
    end
    mem_data_ok = 1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_data_ok = 0;
    pulses = int'(data_ok);
    n_cmp++;
    if (data_rdata !== 32'h12345678) begin
      n_err++; $display("FAIL bp_rdata_kept: got %h want 12345678", data_rdata);
    end
    data_req = 0; data_wr = 0;
    step();
    pulses += int'(data_ok);
    step();
    pulses += int'(data_ok);
    n_cmp++;
    if (pulses !== 1) begin n_err++; $display("FAIL bp_pulse_count: got %0d want 1", pulses); end
  endtask

  task automatic test_fairness();
    logic waitflag;
    logic order[$];
    inst_req = 1; inst_addr = 32'hBFC00100;
    data_req = 1; data_wr = 0; data_addr = 32'h80000030;
    mem_rdata = 32'h00000001;
    waitflag = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      step();
      mem_data_ok = waitflag;
      waitflag    = mem_req;
      mem_addr_ok = mem_req;
      if (mem_req) order.push_back(mem_addr == 32'h80000030);
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    step(); step();
    n_cmp++;
    if (order.size() !== 6) begin
      n_err++; $display("FAIL fair_grants: got %0d want 6", order.size());
    end
    for (int unsigned k = 0; k < order.size(); k++) begin
      n_cmp++;
      if (order[k] !== ((k % 2) == 0)) begin
        n_err++; $display("FAIL fair_order_%0d: got data=%b want data=%b", k, order[k], (k % 2) == 0);
      end
    end
  endtask

  task automatic test_reset_midflight();
    data_req = 1; data_wr = 0; data_addr = 32'h80000040;
    step();
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0;
    rst = 0; data_req = 0;
    #1;
    n_cmp++;
    if ({mem_req, mem_wr, inst_ok, data_ok, stall, mem_addr, mem_wdata, inst_rdata, data_rdata} !== 133'h0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %b%b%b%b%b/%h/%h/%h/%h want all 0", mem_req, mem_wr, inst_ok, data_ok, stall, mem_addr, mem_wdata, inst_rdata, data_rdata);
    end
    step();
    rst = 1; mem_data_ok = 1; mem_rdata = 32'h55555555;
    step();
    mem_data_ok = 0;
    n_cmp++;
    if ({data_ok, mem_req, data_rdata} !== {2'b00, 32'h0}) begin
      n_err++; $display("FAIL rst_late_dataok: got %b/%b/%h want 0/0/0", data_ok, mem_req, data_rdata);
    end
    data_req = 1; data_wr = 0; data_addr = 32'h80000044;
    step();
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h80000044}) begin
      n_err++; $display("FAIL rst_next_grant: got %b/%h want 1/80000044", mem_req, mem_addr);
    end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0A0B0C0D;
    step();
    mem_data_ok = 0;
    n_cmp++;
    if ({data_ok, data_rdata} !== {1'b1, 32'h0A0B0C0D}) begin
      n_err++; $display("FAIL rst_next_ok: got %b/%h want 1/0a0b0c0d", data_ok, data_rdata);
    end
    data_req = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_backpressure();
    test_fairness();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port inst_req, input, 1, fetch stage requests a read at inst_addr.
REQ-006 SHALL have port inst_addr, input, ADDR_W, fetch address (pc).
REQ-007 SHALL have port inst_rdata, output, DATA_W, fetched instruction word.
REQ-008 SHALL have port inst_ok, output, 1, one-cycle pulse when inst_rdata is valid.
REQ-009 SHALL have port data_req, input, 1, mem stage requests an access.
REQ-010 SHALL have port data_wr, input, 1, 1=store, 0=load.
REQ-011 SHALL have ports data_addr and data_wdata, input, ADDR_W and DATA_W, load/store address and store data.
REQ-012 SHALL have port data_rdata, output, DATA_W, load result.
REQ-013 SHALL have port data_ok, output, 1, one-cycle completion pulse for load or store.
REQ-014 SHALL have ports mem_req, mem_wr, mem_addr, mem_wdata, outputs, 1/1/ADDR_W/DATA_W, the shared memory request.
REQ-015 SHALL have ports mem_addr_ok, mem_data_ok, mem_rdata, inputs, 1/1/DATA_W, memory request-accept, completion and read data.
REQ-016 SHALL have port stall, output, 1, freezes the whole pipeline while any request is outstanding.

Function
REQ-017 SHALL implement FSM states IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT.
REQ-018 IDLE: data_req -> D_ADDR; otherwise inst_req -> I_ADDR; otherwise stay.
REQ-019 On grant, the granted request's address, wr and wdata SHALL be latched; mem_* SHALL drive only latched values.
REQ-020 *_ADDR: mem_req=1; on mem_addr_ok=1 go to the matching *_WAIT with mem_req=0 in the next cycle; otherwise hold all values.
REQ-021 *_WAIT: on mem_data_ok=1, register mem_rdata into inst_rdata/data_rdata, pulse the matching *_ok next cycle, and return to IDLE.
REQ-022 After a data completion, a pending inst_req SHALL be granted in the IDLE cycle after the data_ok pulse, ahead of any new data_req (no fetch starvation).
REQ-023 mem_data_ok SHALL be ignored in IDLE and *_ADDR; mem_addr_ok SHALL be ignored outside *_ADDR.
REQ-024 Store: data_rdata SHALL be left unchanged; data_ok SHALL still pulse.
REQ-025 stall SHALL be combinational: (inst_req|data_req) and not (the cycle in which every asserted request has received its *_ok).
REQ-026 inst_rdata and data_rdata SHALL hold their value until the next completion of the same side.
REQ-027 Minimum latency: grant to *_ok is 3 cycles when mem_addr_ok and mem_data_ok each respond in their first eligible cycle.
REQ-028 Requests SHALL be level-held by the pipeline until *_ok; deasserting a request mid-transaction SHALL NOT abort it.

Reset
REQ-029 rst=0 SHALL asynchronously force state IDLE; mem_req, mem_wr, inst_ok, data_ok = 0; mem_addr, mem_wdata, inst_rdata, data_rdata = 0.
REQ-030 Reset mid-transaction SHALL abandon it; a late mem_data_ok after reset release SHALL be ignored (REQ-023).
REQ-031 The first grant after reset release SHALL occur no earlier than the first rising edge with rst=1.

Structure
REQ-032 FSM state encodings SHALL be localparams in the shared defines header alongside the existing pipeline control constants.
REQ-033 The block SHALL be a single module with no sub-modules; it sits between the datapath's fetch/mem ports and the unified memory in the mips top level.

Verification
REQ-034 Instruction fetch: inst_req=1, inst_addr=0xBFC00000, memory returns 0x24020005 with addr_ok/data_ok on the first eligible cycles -> inst_ok pulses 3 cycles after grant, inst_rdata=0x24020005, stall low in the inst_ok cycle.
REQ-035 Simultaneous requests: inst_req and data_req (load 0x80000010 -> 0x12345678) both asserted in the same cycle -> data is served first, data_rdata=0x12345678, then the fetch is served; stall stays high until inst_ok.
REQ-036 Backpressure: store to 0x80000020 with data 0xDEADBEEF, mem_addr_ok held low for 5 cycles -> mem_addr/mem_wdata/mem_wr=1 stable all 5 cycles; data_ok pulses once; data_rdata unchanged.
REQ-037 Fairness: data_req held high continuously with inst_req pending -> fetches and data accesses alternate grants.
REQ-038 Reset mid-flight: rst low during D_WAIT, then mem_data_ok after release -> no data_ok; all outputs 0; next request is served normally.
